// File: rtl/pwr_btn_conditioner.sv
// Power-button conditioner: synchroniser, debouncer, hold timer and enable sequencer.
// Optional macro PWR_BTN_4S_PULSE_EN turns o_btn_press4s into a one-shot pulse.
module pwr_btn_conditioner #(
    parameter int DEB_CNT  = 655,
    parameter int HOLD_CNT = 131072,
    parameter int EN_DLY   = 32768
) (
    input  logic i_clk_32k,
    input  logic i_rst_n,
    input  logic i_pwr_btn_n,
    output logic o_ButtonPressed,
    output logic o_btn_press4s,
    output logic o_pwr_btn_en,
    output logic o_btn_stuck
);

    localparam int DCW = $clog2(DEB_CNT + 1);
    localparam int HCW = $clog2(HOLD_CNT + 1);
    localparam int ECW = (EN_DLY > 1) ? $clog2(EN_DLY) : 1;

    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CNT - 1);
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(HOLD_CNT);
    localparam logic [ECW-1:0] ECNT_LAST = ECW'(EN_DLY - 1);

    typedef enum logic [1:0] {
        S_DLY = 2'd0,
        S_CHK = 2'd1,
        S_RUN = 2'd2
    } state_e;

    logic           sync1_q, sync2_q;
    logic           deb_q, deb_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic           at_hold;
    state_e         state_q, state_d;
    logic [ECW-1:0] ecnt_q, ecnt_d;
    logic           en_q, en_d;
    logic           stuck_q, stuck_d;

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            state_q <= S_DLY;
            ecnt_q  <= '0;
            en_q    <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            sync1_q <= i_pwr_btn_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            state_q <= state_d;
            ecnt_q  <= ecnt_d;
            en_q    <= en_d;
            stuck_q <= stuck_d;
        end
    end

    assign at_hold = (hcnt_q == HOLD_MAX);

    // Any sample matching the accepted level restarts the stability count.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        if (~sync2_q != deb_q) begin
            if (dcnt_q == DEB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                dcnt_d = dcnt_q + DCW'(1);
            end
        end
        hcnt_d = '0;
        if (deb_q) begin
            hcnt_d = at_hold ? hcnt_q : hcnt_q + HCW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ecnt_d  = ecnt_q;
        en_d    = en_q;
        stuck_d = stuck_q;
        case (state_q)
            S_DLY: begin
                if (ecnt_q == ECNT_LAST) begin
                    state_d = S_CHK;
                    stuck_d = deb_q;
                end else begin
                    ecnt_d = ecnt_q + ECW'(1);
                end
            end
            S_CHK: begin
                if (!deb_q) begin
                    state_d = S_RUN;
                    en_d    = 1'b1;
                    stuck_d = 1'b0;
                end else begin
                    stuck_d = 1'b1;
                end
            end
            S_RUN: begin
                en_d    = 1'b1;
                stuck_d = 1'b0;
            end
            default: begin
                state_d = S_DLY;
            end
        endcase
    end

`ifdef PWR_BTN_4S_PULSE_EN
    // fired_q blocks re-pulsing until a release is accepted.
    logic fired_q, fired_d;

    assign fired_d = deb_q & (fired_q | at_hold);

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fired_q <= 1'b0;
        end else begin
            fired_q <= fired_d;
        end
    end

    assign o_btn_press4s = deb_q & at_hold & ~fired_q;
`else
    assign o_btn_press4s = deb_q & at_hold;
`endif

    assign o_ButtonPressed = deb_q;
    assign o_pwr_btn_en    = en_q;
    assign o_btn_stuck     = stuck_q;

endmodule
